// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep harness.
// Sizing helpers assume at most 64 truth-table rows (N_IN <= 6).
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } tt_state_t;

    localparam int TT_MAX_ROWS = 64;

    function automatic int tt_rows(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int unsigned tt_popcount(input logic [TT_MAX_ROWS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < TT_MAX_ROWS; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Per-row settle counter: counts 0..SETTLE-1 while running and flags the
// last cycle (capture) and, with TT_GLITCH_CHECK_EN, the cycle before it.
module tt_settle_timer #(
    parameter int SETTLE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic last
`ifdef TT_GLITCH_CHECK_EN
    ,
    output logic early
`endif
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign last = run && (cnt_q == CW'(SETTLE - 1));
`ifdef TT_GLITCH_CHECK_EN
    assign early = run && (cnt_q == CW'(SETTLE - 2));
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = last ? '0 : cnt_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_sweep_harness.sv
// Sweeps all 2**N_IN input rows of a combinational circuit, captures its truth
// table and scores it against EXPECTED. Optional macro: TT_GLITCH_CHECK_EN.
module tt_sweep_harness
    import tt_sweep_pkg::*;
#(
    parameter int                          N_IN     = 4,
    parameter int                          SETTLE   = 4,
    parameter logic [tt_rows(N_IN)-1:0]    EXPECTED = 16'h0643
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [N_IN-1:0]           in_vec,
    input  logic                      dut_out,
    output logic                      busy,
    output logic                      done,
    output logic [tt_rows(N_IN)-1:0]  table_out,
    output logic                      match,
    output logic [N_IN:0]             hdist
`ifdef TT_GLITCH_CHECK_EN
    ,
    output logic [tt_rows(N_IN)-1:0]  unstable_rows
`endif
);

    localparam int ROWS = tt_rows(N_IN);
    localparam int HW   = N_IN + 1;

    tt_state_t         state_q, state_d;
    logic [N_IN-1:0]   row_q, row_d;
    logic [ROWS-1:0]   table_q, table_d;
    logic              match_q, match_d;
    logic [HW-1:0]     hdist_q, hdist_d;
    logic              timer_clear;
    logic              timer_run;
    logic              timer_last;
`ifdef TT_GLITCH_CHECK_EN
    logic              timer_early;
    logic              early_q, early_d;
    logic [ROWS-1:0]   unstable_q, unstable_d;
`endif

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .run   (timer_run),
        .last  (timer_last)
`ifdef TT_GLITCH_CHECK_EN
        ,
        .early (timer_early)
`endif
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        table_d     = table_q;
        match_d     = match_q;
        hdist_d     = hdist_q;
        timer_clear = 1'b0;
        timer_run   = 1'b0;
`ifdef TT_GLITCH_CHECK_EN
        early_d     = early_q;
        unstable_d  = unstable_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = DRIVE;
                    row_d       = '0;
                    table_d     = '0;
                    match_d     = 1'b0;
                    hdist_d     = '0;
                    timer_clear = 1'b1;
`ifdef TT_GLITCH_CHECK_EN
                    early_d     = 1'b0;
                    unstable_d  = '0;
`endif
                end
            end

            DRIVE: begin
                timer_run = 1'b1;
`ifdef TT_GLITCH_CHECK_EN
                if (timer_early) begin
                    early_d = dut_out;
                end
`endif
                if (timer_last) begin
                    table_d[row_q] = dut_out;
`ifdef TT_GLITCH_CHECK_EN
                    if (early_q != dut_out) begin
                        unstable_d[row_q] = 1'b1;
                    end
`endif
                    if (row_q == N_IN'(ROWS - 1)) begin
                        // Score from the next-state table so results are valid during DONE.
                        state_d = DONE;
                        hdist_d = HW'(tt_popcount(TT_MAX_ROWS'(table_d ^ EXPECTED)));
`ifdef TT_GLITCH_CHECK_EN
                        match_d = (table_d == EXPECTED) && (unstable_d == '0);
`else
                        match_d = (table_d == EXPECTED);
`endif
                    end else begin
                        row_d = row_q + N_IN'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            table_q    <= '0;
            match_q    <= 1'b0;
            hdist_q    <= '0;
`ifdef TT_GLITCH_CHECK_EN
            early_q    <= 1'b0;
            unstable_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            table_q    <= table_d;
            match_q    <= match_d;
            hdist_q    <= hdist_d;
`ifdef TT_GLITCH_CHECK_EN
            early_q    <= early_d;
            unstable_q <= unstable_d;
`endif
        end
    end

    assign busy      = (state_q == DRIVE);
    assign done      = (state_q == DONE);
    assign in_vec    = busy ? row_q : '0;
    assign table_out = table_q;
    assign match     = match_q;
    assign hdist     = hdist_q;
`ifdef TT_GLITCH_CHECK_EN
    assign unstable_rows = unstable_q;
`endif

endmodule
